// File: rtl/mbus_mem_slave_if.sv
// mbus memory-slave bus bundle: AR/R read channels, AW+W write beat, B response.
// Signal names follow the bus pin names so waveforms match the system netlist.
interface mbus_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   mbus_ar_addr;
    logic                    mbus_ar_valid;
    logic                    mbus_ar_ready;
    logic [DATA_WIDTH-1:0]   mbus_r_data;
    logic                    mbus_r_valid;
    logic                    mbus_r_ready;
    logic [ADDR_WIDTH-1:0]   mbus_aw_addr;
    logic                    mbus_aw_valid;
    logic                    mbus_aw_ready;
    logic [DATA_WIDTH-1:0]   mbus_w_data;
    logic                    mbus_w_valid;
    logic [DATA_WIDTH/8-1:0] mbus_w_strb;
    logic                    mbus_b_resp;
    logic                    mbus_b_valid;
    logic                    mbus_b_ready;

    modport slave (
        input  mbus_ar_addr, mbus_ar_valid,
        output mbus_ar_ready,
        output mbus_r_data, mbus_r_valid,
        input  mbus_r_ready,
        input  mbus_aw_addr, mbus_aw_valid,
        output mbus_aw_ready,
        input  mbus_w_data, mbus_w_valid, mbus_w_strb,
        output mbus_b_resp, mbus_b_valid,
        input  mbus_b_ready
    );

    modport master (
        output mbus_ar_addr, mbus_ar_valid,
        input  mbus_ar_ready,
        input  mbus_r_data, mbus_r_valid,
        output mbus_r_ready,
        output mbus_aw_addr, mbus_aw_valid,
        input  mbus_aw_ready,
        output mbus_w_data, mbus_w_valid, mbus_w_strb,
        input  mbus_b_resp, mbus_b_valid,
        output mbus_b_ready
    );
endinterface

// File: rtl/mbus_mem_slave.sv
// Word-addressed single-port memory slave for the VFU mbus.
// Reads: array read at the AR edge, fixed-latency shift register, in-order
// return FIFO, credit counter bounding outstanding reads.
// Writes: AW and W consumed together, byte strobes, one B response per beat.
module mbus_mem_slave #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2,
    parameter int RQ_DEPTH     = 4,
    parameter int BQ_DEPTH     = 4
) (
    input  logic            clk,
    input  logic            reset,
    mbus_mem_slave_if.slave mbus
);
    localparam int WORD_AW = $clog2(DEPTH_WORDS);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int RQ_CW   = $clog2(RQ_DEPTH) + 1;
    localparam int BQ_CW   = $clog2(BQ_DEPTH) + 1;
    localparam int RQ_PW   = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int BQ_PW   = (BQ_DEPTH > 1) ? $clog2(BQ_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS) << 2;

    // NOTE: the storage array has no reset -- contents must survive a bus reset,
    // and a reset would also stop it mapping onto block/distributed RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // ---------------------------------------------------------------- decode
    logic               ar_ready, aw_ready;
    logic               ar_hs, wr_beat;
    logic               ar_in_range, aw_in_range;
    logic [WORD_AW-1:0] ar_idx, aw_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [RQ_CW-1:0] rd_credits_q, rd_credits_d;
    logic [BQ_CW-1:0] b_count_q, b_count_d;

    assign ar_in_range = ({1'b0, mbus.mbus_ar_addr} < ADDR_LIMIT);
    assign aw_in_range = ({1'b0, mbus.mbus_aw_addr} < ADDR_LIMIT);
    assign ar_idx      = mbus.mbus_ar_addr[WORD_AW+1:2];
    assign aw_idx      = mbus.mbus_aw_addr[WORD_AW+1:2];

    // Readiness depends only on registered counts, so a pop frees a slot one cycle later.
    assign ar_ready = ~reset & (rd_credits_q < RQ_CW'(RQ_DEPTH));
    assign aw_ready = ~reset & (b_count_q < BQ_CW'(BQ_DEPTH));
    assign ar_hs    = mbus.mbus_ar_valid & ar_ready;
    assign wr_beat  = mbus.mbus_aw_valid & aw_ready & mbus.mbus_w_valid;

    assign mbus.mbus_ar_ready = ar_ready;
    assign mbus.mbus_aw_ready = aw_ready;

    // Array read for the current AR; out-of-range addresses return zero.
    always_comb begin
        // NOTE: default first so every path assigns rd_word and no latch is inferred.
        rd_word = '0;
        if (ar_in_range) rd_word = mem_q[ar_idx];
    end

    // Strobed array write; read-first because the array read above sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (wr_beat && aw_in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                // NOTE: non-blocking so any same-edge read still observes the old word.
                if (mbus.mbus_w_strb[i]) mem_q[aw_idx][8*i +: 8] <= mbus.mbus_w_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------ read latency pipe
    logic                  push_vld;
    logic [DATA_WIDTH-1:0] push_data;

    if (READ_LATENCY == 1) begin : g_no_pipe
        assign push_vld  = ar_hs;
        assign push_data = rd_word;
    end else begin : g_pipe
        localparam int STAGES = READ_LATENCY - 1;
        logic [STAGES-1:0]     vld_q;
        logic [DATA_WIDTH-1:0] data_q [STAGES];

        // Valid bits shift toward the return FIFO; cleared on reset to drop in-flight reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= ar_hs;
                for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
            end
        end

        // Data rides alongside its valid bit; it is only consumed when valid.
        always_ff @(posedge clk) begin
            data_q[0] <= rd_word;
            for (int k = 1; k < STAGES; k++) data_q[k] <= data_q[k-1];
        end

        assign push_vld  = vld_q[STAGES-1];
        assign push_data = data_q[STAGES-1];
    end

    // ------------------------------------------------------ read return FIFO
    logic [DATA_WIDTH-1:0] rq_mem_q [RQ_DEPTH];
    logic [RQ_PW-1:0]      rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
    logic [RQ_CW-1:0]      rq_cnt_q, rq_cnt_d;
    logic                  r_valid, r_pop;

    function automatic logic [RQ_PW-1:0] rq_next(input logic [RQ_PW-1:0] p);
        return (p == RQ_PW'(RQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign r_valid           = ~reset & (rq_cnt_q != '0);
    assign r_pop             = r_valid & mbus.mbus_r_ready;
    assign mbus.mbus_r_valid = r_valid;
    assign mbus.mbus_r_data  = r_valid ? rq_mem_q[rq_rd_q] : '0;

    // Next-state for the return FIFO pointers, occupancy and read credits.
    always_comb begin
        rq_wr_d      = rq_wr_q;
        rq_rd_d      = rq_rd_q;
        rq_cnt_d     = rq_cnt_q;
        rd_credits_d = rd_credits_q;
        if (push_vld) rq_wr_d = rq_next(rq_wr_q);
        if (r_pop)    rq_rd_d = rq_next(rq_rd_q);
        if (push_vld && !r_pop)      rq_cnt_d = rq_cnt_q + 1'b1;
        else if (!push_vld && r_pop) rq_cnt_d = rq_cnt_q - 1'b1;
        if (ar_hs && !r_pop)         rd_credits_d = rd_credits_q + 1'b1;
        else if (!ar_hs && r_pop)    rd_credits_d = rd_credits_q - 1'b1;
    end

    // Read-side state registers; reset discards queued read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rq_wr_q      <= '0;
            rq_rd_q      <= '0;
            rq_cnt_q     <= '0;
            rd_credits_q <= '0;
        end else begin
            rq_wr_q      <= rq_wr_d;
            rq_rd_q      <= rq_rd_d;
            rq_cnt_q     <= rq_cnt_d;
            rd_credits_q <= rd_credits_d;
        end
    end

    // Return FIFO storage; credits guarantee a free slot whenever data arrives.
    always_ff @(posedge clk) begin
        if (push_vld) rq_mem_q[rq_wr_q] <= push_data;
    end

    // ------------------------------------------------------ B response FIFO
    logic             bq_mem_q [BQ_DEPTH];
    logic [BQ_PW-1:0] bq_wr_q, bq_wr_d, bq_rd_q, bq_rd_d;
    logic             b_valid, b_pop;

    function automatic logic [BQ_PW-1:0] bq_next(input logic [BQ_PW-1:0] p);
        return (p == BQ_PW'(BQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign b_valid           = ~reset & (b_count_q != '0);
    assign b_pop             = b_valid & mbus.mbus_b_ready;
    assign mbus.mbus_b_valid = b_valid;
    assign mbus.mbus_b_resp  = b_valid & bq_mem_q[bq_rd_q];

    // Next-state for the B FIFO pointers and occupancy.
    always_comb begin
        bq_wr_d   = bq_wr_q;
        bq_rd_d   = bq_rd_q;
        b_count_d = b_count_q;
        if (wr_beat) bq_wr_d = bq_next(bq_wr_q);
        if (b_pop)   bq_rd_d = bq_next(bq_rd_q);
        if (wr_beat && !b_pop)      b_count_d = b_count_q + 1'b1;
        else if (!wr_beat && b_pop) b_count_d = b_count_q - 1'b1;
    end

    // Write-side state registers; reset discards pending responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bq_wr_q   <= '0;
            bq_rd_q   <= '0;
            b_count_q <= '0;
        end else begin
            bq_wr_q   <= bq_wr_d;
            bq_rd_q   <= bq_rd_d;
            b_count_q <= b_count_d;
        end
    end

    // B FIFO storage: response is 1 when the beat addressed beyond the array.
    always_ff @(posedge clk) begin
        if (wr_beat) bq_mem_q[bq_wr_q] <= ~aw_in_range;
    end
endmodule
